mul_div_unit: RTL

- Executes RV32M operations selected by the 4-bit mulDiv_op code from the instruction decoder.
- Sits in the execute stage beside the ALU. Accepts one operation at a time and holds the pipeline through busy.
- Multiply completes in 2 cycles. Divide/remainder is a 34-cycle iterative restoring divider. Divide-by-zero and signed-overflow cases take a 1-cycle fast path.

---
 rtl/mul_div_pkg.sv | 33 +++
 rtl/mul_div_divider.sv | 70 +++++++
 rtl/mul_div_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states, width.
package mul_div_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [3:0] OP_NONE   = 4'b0000;
  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MULH   = 4'b0101;
  localparam logic [3:0] OP_MULHSU = 4'b0110;
  localparam logic [3:0] OP_MULHU  = 4'b0111;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  // True for the eight RV32M codes; everything else (including OP_NONE) is ignored.
  function automatic logic is_valid_op(input logic [3:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock after load.
module mul_div_divider
  import mul_div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Shift in the next dividend bit and trial-subtract; borrow keeps the shifted value.
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CW'(XLEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (diff[XLEN]) begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end else begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end
    end
  end

  // Divider datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CW'(1));

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execute-stage unit: 2-cycle multiply, 34-cycle divide, 1-cycle special cases.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      mul_div_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned   PW      = 2 * XLEN;
  localparam int unsigned   CNTW    = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [CNTW-1:0] cnt_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            q_neg_q, r_neg_q;

  logic            accept, op_is_div, op_signed_div, op_is_rem;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] special_res, a_mag, b_mag;
  logic            a_sgn, b_sgn;
  logic signed [XLEN:0] a_ext, b_ext;
  logic signed [PW-1:0] prod;
  logic [XLEN-1:0] mul_res, div_res;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            div_last;

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = ~ready;

  // Acceptance decode, special-case detection, operand magnitudes and result shaping.
  always_comb begin
    op_is_div     = mul_div_op[3];
    op_signed_div = op_is_div & ~mul_div_op[1];
    op_is_rem     = mul_div_op[2];
    accept        = start & ready & is_valid_op(mul_div_op) & ~flush;
    div_by_zero   = (rs2 == '0);
    div_ovf       = op_signed_div & (rs1 == INT_MIN) & (rs2 == '1);
    if (div_by_zero) special_res = op_is_rem ? rs1 : '1;
    else             special_res = op_is_rem ? '0  : rs1;
    a_mag = (op_signed_div & rs1[XLEN-1]) ? ('0 - rs1) : rs1;
    b_mag = (op_signed_div & rs2[XLEN-1]) ? ('0 - rs2) : rs2;

    a_sgn   = (op_q != OP_MULHU);
    b_sgn   = (op_q == OP_MUL) || (op_q == OP_MULH);
    a_ext   = {a_sgn & a_q[XLEN-1], a_q};
    b_ext   = {b_sgn & b_q[XLEN-1], b_q};
    prod    = PW'(a_ext) * PW'(b_ext);
    mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

    if (op_q[2]) div_res = r_neg_q ? ('0 - div_rem) : div_rem;
    else         div_res = q_neg_q ? ('0 - div_quo) : div_quo;
  end

  mul_div_divider #(
    .XLEN (XLEN)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept & op_is_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  // Control FSM; result and done are registered and only change on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= OP_NONE;
      a_q      <= '0;
      b_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (accept) begin
              op_q    <= mul_div_op;
              a_q     <= rs1;
              b_q     <= rs2;
              q_neg_q <= op_signed_div & (rs1[XLEN-1] ^ rs2[XLEN-1]);
              r_neg_q <= op_signed_div & rs1[XLEN-1];
              if (!op_is_div) begin
                state_q <= S_MUL;
              end else if (div_by_zero || div_ovf) begin
                state_q  <= S_DONE;
                result_q <= special_res;
                done_q   <= 1'b1;
              end else begin
                state_q <= S_DIV;
                cnt_q   <= CNTW'(XLEN - 1);
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_MUL: begin
            state_q  <= S_DONE;
            result_q <= mul_res;
            done_q   <= 1'b1;
          end
          S_DIV: begin
            cnt_q <= cnt_q - CNTW'(1);
            if (div_last) state_q <= S_FIX;
          end
          S_FIX: begin
            state_q  <= S_DONE;
            result_q <= div_res;
            done_q   <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
